// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants
package alu_pkg;

  localparam int LIMB_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mp_sub_sequencer.sv
// rtl/mp_sub_sequencer.sv - multi-precision subtract sequencer feeding a registered limb subtractor
module mp_sub_sequencer
  import alu_pkg::*;
#(
  parameter int WORDS  = 4,
  parameter int LIMB_W = LIMB_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORDS*LIMB_W-1:0]   in_a,
  input  logic [WORDS*LIMB_W-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORDS*LIMB_W-1:0]   out_diff,
  output logic                      out_borrow,
  output logic                      out_zero,
  output logic [LIMB_W-1:0]         sub_a,
  output logic [LIMB_W-1:0]         sub_b,
  output logic                      sub_borrow_in,
  input  logic [LIMB_W-1:0]         sub_difference,
  input  logic                      sub_borrow_out
);

  localparam int IDX_W = idx_width(WORDS);
  localparam int TOT_W = WORDS * LIMB_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  seq_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [TOT_W-1:0]  r_a, r_b, r_diff, w_diff_wr;
  logic [LIMB_W-1:0] r_sub_a, r_sub_b;
  logic              r_sub_bin, r_borrow, r_zero, r_valid;
  logic              w_last;

  assign w_last    = (r_idx == LAST_IDX);
  assign w_idx_nxt = r_idx + IDX_W'(1);

  // Result with the incoming limb merged in, so the zero flag sees the final limb too.
  always_comb begin
    w_diff_wr = r_diff;
    w_diff_wr[r_idx*LIMB_W +: LIMB_W] = sub_difference;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_ISSUE;
      S_ISSUE:                w_state_nxt = S_WAIT;
      S_WAIT:                 w_state_nxt = w_last ? S_DONE : S_ISSUE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_diff    <= '0;
      r_sub_a   <= '0;
      r_sub_b   <= '0;
      r_sub_bin <= 1'b0;
      r_borrow  <= 1'b0;
      r_zero    <= 1'b1;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a       <= in_a;
          r_b       <= in_b;
          r_idx     <= '0;
          r_sub_a   <= in_a[LIMB_W-1:0];
          r_sub_b   <= in_b[LIMB_W-1:0];
          r_sub_bin <= 1'b0;
        end
        S_WAIT: begin
          r_diff   <= w_diff_wr;
          r_borrow <= sub_borrow_out;
          if (w_last) begin
            r_valid <= 1'b1;
            r_zero  <= (w_diff_wr == '0);
          end else begin
            r_idx     <= w_idx_nxt;
            r_sub_a   <= r_a[w_idx_nxt*LIMB_W +: LIMB_W];
            r_sub_b   <= r_b[w_idx_nxt*LIMB_W +: LIMB_W];
            r_sub_bin <= sub_borrow_out;
          end
        end
        S_DONE: if (out_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign out_valid     = r_valid;
  assign out_diff      = r_diff;
  assign out_borrow    = r_borrow;
  assign out_zero      = r_zero;
  assign sub_a         = r_sub_a;
  assign sub_b         = r_sub_b;
  assign sub_borrow_in = r_sub_bin;

endmodule
